// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
// A start/done handshake brackets each job; bin/ovf/err hold until the next done.
module bcd_to_bin_seq #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned MAX_VAL  = 8191
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  ovf,
  output logic                  err
);

  localparam int unsigned SR_W  = 4*N_DIGITS + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d, sr_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               digit_bad;

  always_comb begin
    digit_bad = 1'b0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (bcd_in[4*k +: 4] > 4'd9) digit_bad = 1'b1;
    end

    // Shift right, then pull every BCD field that crossed into 8..15 back down by 3.
    sr_step = sr_q >> 1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (sr_step[BIN_W + 4*k +: 4] >= 4'd8)
        sr_step[BIN_W + 4*k +: 4] = sr_step[BIN_W + 4*k +: 4] - 4'd3;
    end

    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (digit_bad) begin
            bin_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            sr_d    = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bin_d   = sr_step[BIN_W-1:0];
          ovf_d   = 32'(sr_step[BIN_W-1:0]) > MAX_VAL;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = bin_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule
